// File: rtl/soc_rom_arbiter.sv
// soc_rom_arbiter: shares the asynchronous-read system ROM between the
// instruction-fetch port and the data-load port. Every access is a req/ack
// transaction with a fixed number of extra wait cycles. Read data and the
// error flag are held in per-port registers.
//
// Build option: define SOC_ROM_ARB_RR_EN for round-robin arbitration on ties.
// Without it, the instruction port always wins a tie.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for a request; arbitrate and latch the address
// S_ACCESS | ROM address driven; wait counter runs down to 0, then capture
// S_RESP   | one-cycle ack to the granted port; requests are ignored
module soc_rom_arbiter #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 15,
   parameter int ROM_WORDS   = 32768,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic                  i_ack,
   output logic [DATA_WIDTH-1:0] i_data,
   output logic                  i_err,
   input  logic                  d_req,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   output logic                  d_ack,
   output logic [DATA_WIDTH-1:0] d_data,
   output logic                  d_err,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   output logic                  busy
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   // One extra bit so ROM_WORDS == 2**ADDR_WIDTH is representable.
   localparam logic [ADDR_WIDTH:0] ROM_LIMIT = (ADDR_WIDTH+1)'(ROM_WORDS);
   localparam logic [3:0]          WAIT_LOAD = 4'(WAIT_CYCLES);

   state_t                state_q, state_d;
   logic                  gnt_d_q, gnt_d_d;   // 1: data port owns the access
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] i_data_q, i_data_d, d_data_q, d_data_d;
   logic                  i_err_q, i_err_d, d_err_q, d_err_d;

   logic                  sel_d;
   logic [ADDR_WIDTH-1:0] gnt_addr;
   logic                  in_range;

`ifdef SOC_ROM_ARB_RR_EN
   logic rr_q, rr_d;   // 1: data port is favoured on the next tie

   // Round-robin: on a tie the favoured port wins.
   always_comb sel_d = d_req && (!i_req || rr_q);
`else
   // Fixed priority: the data port wins only when the instruction port is idle.
   always_comb sel_d = d_req && !i_req;
`endif

   // Candidate address and range check for the port that would be granted.
   always_comb begin
      gnt_addr = sel_d ? d_addr : i_addr;
      in_range = {1'b0, gnt_addr} < ROM_LIMIT;
   end

   // Next-state, grant and capture logic.
   always_comb begin
      state_d  = state_q;
      gnt_d_d  = gnt_d_q;
      addr_d   = addr_q;
      cnt_d    = cnt_q;
      i_data_d = i_data_q;
      d_data_d = d_data_q;
      i_err_d  = i_err_q;
      d_err_d  = d_err_q;
`ifdef SOC_ROM_ARB_RR_EN
      rr_d     = rr_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (i_req || d_req) begin
               gnt_d_d = sel_d;
`ifdef SOC_ROM_ARB_RR_EN
               rr_d    = !sel_d;
`endif
               if (in_range) begin
                  addr_d  = gnt_addr;
                  cnt_d   = WAIT_LOAD;
                  state_d = S_ACCESS;
               end else begin
                  // Out of range: skip the ROM, leave rom_addr untouched.
                  if (sel_d) begin
                     d_data_d = '0;
                     d_err_d  = 1'b1;
                  end else begin
                     i_data_d = '0;
                     i_err_d  = 1'b1;
                  end
                  state_d = S_RESP;
               end
            end
         end
         S_ACCESS: begin
            if (cnt_q == 4'd0) begin
               if (gnt_d_q) begin
                  d_data_d = rom_data;
                  d_err_d  = 1'b0;
               end else begin
                  i_data_d = rom_data;
                  i_err_d  = 1'b0;
               end
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         gnt_d_q  <= 1'b0;
         addr_q   <= '0;
         cnt_q    <= '0;
         i_data_q <= '0;
         d_data_q <= '0;
         i_err_q  <= 1'b0;
         d_err_q  <= 1'b0;
`ifdef SOC_ROM_ARB_RR_EN
         rr_q     <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         gnt_d_q  <= gnt_d_d;
         addr_q   <= addr_d;
         cnt_q    <= cnt_d;
         i_data_q <= i_data_d;
         d_data_q <= d_data_d;
         i_err_q  <= i_err_d;
         d_err_q  <= d_err_d;
`ifdef SOC_ROM_ARB_RR_EN
         rr_q     <= rr_d;
`endif
      end
   end

   // Outputs come straight from registers.
   always_comb begin
      i_ack    = (state_q == S_RESP) && !gnt_d_q;
      d_ack    = (state_q == S_RESP) &&  gnt_d_q;
      i_data   = i_data_q;
      d_data   = d_data_q;
      i_err    = i_err_q;
      d_err    = d_err_q;
      rom_addr = addr_q;
      busy     = (state_q != S_IDLE);
   end

endmodule

// File: tb/tb_soc_rom_arbiter.sv
// Bench for soc_rom_arbiter. Two instances share clk/rst:
//   dut_a: WAIT_CYCLES=0, ROM_WORDS=1024 (latency, out-of-range, ties)
//   dut_b: WAIT_CYCLES=3, ROM_WORDS=32768 (wait states, mid-access reset)
// Expected acks are queued at issue time; a negedge monitor pops and checks.
module tb_soc_rom_arbiter;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   // queue index: 0 = A instr, 1 = A data, 2 = B instr, 3 = B data
   exp_t q[4][$];

   logic        i_req_a = 0, d_req_a = 0, i_req_b = 0, d_req_b = 0;
   logic [14:0] i_addr_a = 0, d_addr_a = 0, i_addr_b = 0, d_addr_b = 0;
   logic        i_ack_a, d_ack_a, i_err_a, d_err_a, busy_a;
   logic        i_ack_b, d_ack_b, i_err_b, d_err_b, busy_b;
   logic [31:0] i_data_a, d_data_a, rom_data_a, i_data_b, d_data_b, rom_data_b;
   logic [14:0] rom_addr_a, rom_addr_b;

   function automatic logic [31:0] rom_fn(input logic [14:0] a);
      return {a[7:0], ~a[14:7], a ^ 15'h5A5A, 1'b1};
   endfunction

   assign rom_data_a = rom_fn(rom_addr_a);
   assign rom_data_b = rom_fn(rom_addr_b);

   soc_rom_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(15), .ROM_WORDS(1024), .WAIT_CYCLES(0)) dut_a (
      .clk(clk), .rst(rst),
      .i_req(i_req_a), .i_addr(i_addr_a), .i_ack(i_ack_a), .i_data(i_data_a), .i_err(i_err_a),
      .d_req(d_req_a), .d_addr(d_addr_a), .d_ack(d_ack_a), .d_data(d_data_a), .d_err(d_err_a),
      .rom_addr(rom_addr_a), .rom_data(rom_data_a), .busy(busy_a));

   soc_rom_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(15), .ROM_WORDS(32768), .WAIT_CYCLES(3)) dut_b (
      .clk(clk), .rst(rst),
      .i_req(i_req_b), .i_addr(i_addr_b), .i_ack(i_ack_b), .i_data(i_data_b), .i_err(i_err_b),
      .d_req(d_req_b), .d_addr(d_addr_b), .d_ack(d_ack_b), .d_data(d_data_b), .d_err(d_err_b),
      .rom_addr(rom_addr_b), .rom_data(rom_data_b), .busy(busy_b));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic mon(input int p, input string nm, input logic [31:0] data, input logic err);
      exp_t e;
      total++;
      if (q[p].size() == 0) begin
         bad++;
         $display("FAIL %s unexpected ack: got ack=1 expected ack=0 (cycle %0d)", nm, cyc);
      end else begin
         total--;
         e = q[p].pop_front();
         chk({nm, " ack cycle"}, 64'(cyc), 64'(e.cyc));
         chk({nm, " data"}, 64'(data), 64'(e.data));
         chk({nm, " err"}, 64'(err), 64'(e.err));
      end
   endtask

   // Monitor: every ack is matched against the head of its port's queue.
   always @(negedge clk) begin
      if (i_ack_a) mon(0, "A.i", i_data_a, i_err_a);
      if (d_ack_a) mon(1, "A.d", d_data_a, d_err_a);
      if (i_ack_b) mon(2, "B.i", i_data_b, i_err_b);
      if (d_ack_b) mon(3, "B.d", d_data_b, d_err_b);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input int p, input logic [31:0] d, input logic e, input int c);
      exp_t x;
      x.data = d;
      x.err  = e;
      x.cyc  = c;
      q[p].push_back(x);
   endtask

   initial begin
      int c;
      step(3);
      chk("reset busy_a", 64'(busy_a), 0);
      chk("reset rom_addr_a", 64'(rom_addr_a), 0);
      chk("reset i_data_a", 64'(i_data_a), 0);
      chk("reset acks/errs a", 64'({i_ack_a, d_ack_a, i_err_a, d_err_a}), 0);
      rst = 0;
      step(2);

      // A1: single instruction fetch, zero wait states
      c = cyc;
      i_req_a = 1; i_addr_a = 15'h0010;
      push(0, rom_fn(15'h0010), 1'b0, c + 2);
      step(1);
      i_req_a = 0;
      chk("A1 rom_addr", 64'(rom_addr_a), 64'h10);
      chk("A1 busy", 64'(busy_a), 1);
      step(4);

      // A2: last in-range word, then first out-of-range word on the data port
      c = cyc;
      d_req_a = 1; d_addr_a = 15'h03FF;
      push(1, rom_fn(15'h03FF), 1'b0, c + 2);
      step(1);
      d_req_a = 0;
      step(3);
      c = cyc;
      d_req_a = 1; d_addr_a = 15'h0400;
      push(1, 32'h0, 1'b1, c + 1);
      step(1);
      d_req_a = 0;
      chk("A2 rom_addr unchanged", 64'(rom_addr_a), 64'h3FF);
      step(2);
      chk("A2 i_data untouched", 64'(i_data_a), 64'(rom_fn(15'h0010)));
      chk("A2 busy idle", 64'(busy_a), 0);

      // A3: address changes after grant; the latched address is used
      c = cyc;
      i_req_a = 1; i_addr_a = 15'h0020;
      push(0, rom_fn(15'h0020), 1'b0, c + 2);
      step(1);
      i_addr_a = 15'h0030;
      step(2);
      i_req_a = 0;
      step(3);

      // A4: both ports held high for four grants, right after reset
      rst = 1;
      step(1);
      rst = 0;
      step(1);
      c = cyc;
      i_req_a = 1; i_addr_a = 15'h0040;
      d_req_a = 1; d_addr_a = 15'h0050;
`ifdef SOC_ROM_ARB_RR_EN
      push(0, rom_fn(15'h0040), 1'b0, c + 2);
      push(1, rom_fn(15'h0050), 1'b0, c + 5);
      push(0, rom_fn(15'h0040), 1'b0, c + 8);
      push(1, rom_fn(15'h0050), 1'b0, c + 11);
`else
      push(0, rom_fn(15'h0040), 1'b0, c + 2);
      push(0, rom_fn(15'h0040), 1'b0, c + 5);
      push(0, rom_fn(15'h0040), 1'b0, c + 8);
      push(0, rom_fn(15'h0040), 1'b0, c + 11);
`endif
      step(12);
      i_req_a = 0; d_req_a = 0;
      step(4);

      // B1: data port, three wait states, top address
      c = cyc;
      d_req_b = 1; d_addr_b = 15'h7FFF;
      push(3, rom_fn(15'h7FFF), 1'b0, c + 5);
      chk("B1 busy cycle 0", 64'(busy_b), 0);
      for (int k = 1; k <= 5; k++) begin
         step(1);
         d_req_b = 0;
         chk($sformatf("B1 busy cycle %0d", k), 64'(busy_b), 1);
      end
      step(1);
      chk("B1 busy after", 64'(busy_b), 0);
      step(2);

      // B2: reset in the second ACCESS cycle aborts without an ack
      c = cyc;
      i_req_b = 1; i_addr_b = 15'h0123;
      step(1);
      i_req_b = 0;
      step(1);
      rst = 1;
      step(1);
      chk("B2 busy after reset", 64'(busy_b), 0);
      chk("B2 d_data after reset", 64'(d_data_b), 0);
      chk("B2 i_data after reset", 64'(i_data_b), 0);
      chk("B2 rom_addr after reset", 64'(rom_addr_b), 0);
      rst = 0;
      step(8);

      for (int p = 0; p < 4; p++)
         chk($sformatf("missing acks port %0d", p), 64'(q[p].size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got cycle %0d expected finish", cyc);
      $fatal(1, "timeout");
   end

endmodule
